// File: rtl/tmp_buf_rd_arbiter_if.sv
// Read request/response channel shared by the tmp-buf read arbiter ports.
// One instance per requester and one toward the tmp buffer.
//   req_val/req_addr/req_rdy    : read request handshake
//   resp_val/resp_data/resp_rdy : read response handshake
// master drives requests and takes responses; slave does the opposite.
interface tmp_buf_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              req_val;
  logic [ADDR_W-1:0] req_addr;
  logic              req_rdy;
  logic              resp_val;
  logic [DATA_W-1:0] resp_data;
  logic              resp_rdy;

  modport master (
    output req_val, req_addr, resp_rdy,
    input  req_rdy, resp_val, resp_data
  );

  modport slave (
    input  req_val, req_addr, resp_rdy,
    output req_rdy, resp_val, resp_data
  );
endinterface

// File: rtl/tmp_buf_rd_arbiter.sv
// Round-robin arbiter sharing the RX temporary payload buffer read port
// between requester 0 (store-buffer RX path) and requester 1 (debug/copy).
// Responses come back in issue order and are steered by an in-order tag FIFO.
//   clk, rst        : clock, asynchronous active-high reset
//   rq0, rq1        : requester channels (slave side)
//   tbuf            : tmp-buf read channel (master side)
//   outst_cnt       : reads in flight
//   err_orphan_resp : sticky, a response arrived with nothing in flight
module tmp_buf_rd_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  tmp_buf_rd_arbiter_if.slave          rq0,
  tmp_buf_rd_arbiter_if.slave          rq1,
  tmp_buf_rd_arbiter_if.master         tbuf,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         err_orphan_resp
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (MAX_OUTST < 2 || (MAX_OUTST & (MAX_OUTST - 1)) != 0) begin : g_bad_outst
    $error("MAX_OUTST must be a power of 2 and at least 2");
  end

  logic                 prio;
  logic [MAX_OUTST-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     cnt;
  logic                 err;

  logic                 sel;
  logic                 full;
  logic                 empty;
  logic                 head;
  logic                 req_val;
  logic                 resp_rdy;
  logic                 grant;
  logic                 pop;
  logic                 orphan;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    resp_data;

  // Request side: pick requester, block on a full tag FIFO (no pop bypass).
  always_comb begin
    full  = (cnt == CNT_W'(MAX_OUTST));
    empty = (cnt == '0);
    if (rq0.req_val && rq1.req_val) begin
      sel = prio;
    end else begin
      sel = rq1.req_val;
    end
    sel_addr = sel ? rq1.req_addr : rq0.req_addr;
    req_val  = (rq0.req_val | rq1.req_val) & ~full & ~rst;
    grant    = req_val & tbuf.req_rdy;
  end

  // Response side: route by FIFO head; drain everything when nothing is in flight.
  always_comb begin
    head      = tag_mem[rd_ptr];
    resp_data = tbuf.resp_data;
    if (empty) begin
      resp_rdy = ~rst;
    end else begin
      resp_rdy = ~rst & (head ? rq1.resp_rdy : rq0.resp_rdy);
    end
    pop    = tbuf.resp_val & resp_rdy & ~empty;
    orphan = tbuf.resp_val & empty & ~rst;
  end

  assign tbuf.req_val   = req_val;
  assign tbuf.req_addr  = sel_addr;
  assign tbuf.resp_rdy  = resp_rdy;

  assign rq0.req_rdy    = tbuf.req_rdy & ~full & ~sel & ~rst;
  assign rq1.req_rdy    = tbuf.req_rdy & ~full & sel & ~rst;
  assign rq0.resp_val   = tbuf.resp_val & ~empty & ~head & ~rst;
  assign rq1.resp_val   = tbuf.resp_val & ~empty & head & ~rst;
  assign rq0.resp_data  = resp_data;
  assign rq1.resp_data  = resp_data;

  assign outst_cnt       = cnt;
  assign err_orphan_resp = err;

  // Tag FIFO, in-flight count, priority and sticky orphan flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio    <= 1'b0;
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      if (grant) begin
        tag_mem[wr_ptr] <= sel;
        wr_ptr          <= wr_ptr + PTR_W'(1);
        prio            <= ~sel;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (grant && !pop) begin
        cnt <= cnt + CNT_W'(1);
      end else if (pop && !grant) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (orphan) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tmp_buf_rd_arbiter.sv
`timescale 1ns/1ps
module tb_tmp_buf_rd_arbiter;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_OUTST = 4;
  localparam int unsigned CNT_W     = 3;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] outst_cnt;
  logic             err_orphan_resp;

  tmp_buf_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rq0 ();
  tmp_buf_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rq1 ();
  tmp_buf_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) tbuf ();

  tmp_buf_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk             (clk),
    .rst             (rst),
    .rq0             (rq0),
    .rq1             (rq1),
    .tbuf            (tbuf),
    .outst_cnt       (outst_cnt),
    .err_orphan_resp (err_orphan_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  // Reference model state
  bit              m_prio;
  int              m_cnt;
  bit              m_err;
  bit              tags[$];
  logic [DATA_W-1:0] pipe[$];
  logic [DATA_W-1:0] expq0[$];
  logic [DATA_W-1:0] expq1[$];
  int              seq;
  bit              resp_en;
  bit              orphan;

  task automatic clear_model();
    tags.delete(); pipe.delete(); expq0.delete(); expq1.delete();
    m_prio = 1'b0; m_cnt = 0; m_err = 1'b0; orphan = 1'b0;
  endtask

  task automatic idle_inputs();
    rq0.req_val = 1'b0; rq0.req_addr = '0; rq0.resp_rdy = 1'b1;
    rq1.req_val = 1'b0; rq1.req_addr = '0; rq1.resp_rdy = 1'b1;
    tbuf.req_rdy = 1'b1; tbuf.resp_val = 1'b0; tbuf.resp_data = '0;
    resp_en = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  // Tmp-buffer model drives its response for this cycle, then outputs settle.
  task automatic settle();
    if (orphan) begin
      tbuf.resp_val = 1'b1; tbuf.resp_data = 32'hDEAD_BEEF;
    end else if (resp_en && pipe.size() > 0) begin
      tbuf.resp_val = 1'b1; tbuf.resp_data = pipe[0];
    end else begin
      tbuf.resp_val = 1'b0; tbuf.resp_data = '0;
    end
    #1;
  endtask

  // Scoreboard: compare this cycle against the model, clock it, update the model.
  task automatic commit();
    bit v0, v1, empty, full, sel, bval, grant, head, rrdy, pop, from_pipe, dut_rrdy, orph;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d;
    v0 = rq0.req_val; v1 = rq1.req_val;
    empty = (tags.size() == 0);
    full  = (m_cnt == MAX_OUTST);
    sel   = (v0 && v1) ? m_prio : v1;
    bval  = (v0 || v1) && !full;
    grant = bval && tbuf.req_rdy;
    head  = empty ? 1'b0 : tags[0];
    rrdy  = empty ? 1'b1 : (head ? rq1.resp_rdy : rq0.resp_rdy);
    pop   = tbuf.resp_val && rrdy && !empty;
    orph  = tbuf.resp_val && empty;
    addr  = sel ? rq1.req_addr : rq0.req_addr;
    from_pipe = !orphan && resp_en && pipe.size() > 0;
    dut_rrdy  = tbuf.resp_rdy;

    n_cmp++;
    if ({tbuf.req_val, rq0.req_rdy, rq1.req_rdy} !==
        {bval, tbuf.req_rdy && !full && !sel, tbuf.req_rdy && !full && sel}) begin
      n_fail++;
      $display("FAIL issue: got val/rdy0/rdy1=%b%b%b expected %b%b%b", tbuf.req_val,
               rq0.req_rdy, rq1.req_rdy, bval, tbuf.req_rdy && !full && !sel,
               tbuf.req_rdy && !full && sel);
    end
    if (bval) begin
      n_cmp++;
      if (tbuf.req_addr !== addr) begin
        n_fail++;
        $display("FAIL req_addr: got %0h expected %0h", tbuf.req_addr, addr);
      end
    end
    n_cmp++;
    if ({rq0.resp_val, rq1.resp_val, tbuf.resp_rdy} !==
        {tbuf.resp_val && !empty && !head, tbuf.resp_val && !empty && head, rrdy}) begin
      n_fail++;
      $display("FAIL resp_route: got val0/val1/rdy=%b%b%b expected %b%b%b", rq0.resp_val,
               rq1.resp_val, tbuf.resp_rdy, tbuf.resp_val && !empty && !head,
               tbuf.resp_val && !empty && head, rrdy);
    end
    n_cmp++;
    if (outst_cnt !== CNT_W'(m_cnt) || err_orphan_resp !== m_err) begin
      n_fail++;
      $display("FAIL cnt_err: got cnt=%0d err=%b expected cnt=%0d err=%b", outst_cnt,
               err_orphan_resp, m_cnt, m_err);
    end
    if (pop) begin
      n_cmp++;
      if (head) begin
        if (expq1.size() == 0 || rq1.resp_data !== expq1[0]) begin
          n_fail++;
          $display("FAIL rq1_data: got %0h expected %0h", rq1.resp_data,
                   expq1.size() ? expq1[0] : '0);
        end
        if (expq1.size() > 0) void'(expq1.pop_front());
      end else begin
        if (expq0.size() == 0 || rq0.resp_data !== expq0[0]) begin
          n_fail++;
          $display("FAIL rq0_data: got %0h expected %0h", rq0.resp_data,
                   expq0.size() ? expq0[0] : '0);
        end
        if (expq0.size() > 0) void'(expq0.pop_front());
      end
    end
    d = {16'(seq), 7'd0, sel, addr};

    @(posedge clk);
    if (from_pipe && dut_rrdy) void'(pipe.pop_front());
    if (pop) void'(tags.pop_front());
    if (grant) begin
      tags.push_back(sel);
      pipe.push_back(d);
      if (sel) expq1.push_back(d); else expq0.push_back(d);
      m_prio = !sel;
      seq++;
    end
    m_cnt = m_cnt + (grant ? 1 : 0) - (pop ? 1 : 0);
    if (orph) m_err = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    rq0.req_val = 1'b0; rq1.req_val = 1'b0;
    rq0.resp_rdy = 1'b1; rq1.resp_rdy = 1'b1; resp_en = 1'b1;
    for (int k = 0; k < 20 && tags.size() > 0; k++) begin
      settle(); commit();
    end
    n_cmp++;
    if (tags.size() != 0 || outst_cnt !== '0) begin
      n_fail++;
      $display("FAIL drain: got cnt=%0d expected 0 (model left %0d)", outst_cnt, tags.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rq0.req_val = 1'b1; rq1.req_val = 1'b1; tbuf.req_rdy = 1'b1; tbuf.resp_val = 1'b1;
    #1;
    n_cmp++;
    if ({rq0.req_rdy, rq1.req_rdy, tbuf.req_val, rq0.resp_val, rq1.resp_val,
         tbuf.resp_rdy, err_orphan_resp} !== 7'b0 || outst_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy0/rdy1/val/rv0/rv1/rrdy/err=%b%b%b%b%b%b%b cnt=%0d expected all 0",
               rq0.req_rdy, rq1.req_rdy, tbuf.req_val, rq0.resp_val, rq1.resp_val,
               tbuf.resp_rdy, err_orphan_resp, outst_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    clear_model();
    settle(); commit();
  endtask

  task automatic test_single();
    apply_reset();
    rq0.req_val = 1'b1; rq0.req_addr = 8'h05;
    settle();
    n_cmp++;
    if (rq0.req_rdy !== 1'b1 || rq1.req_rdy !== 1'b0 || tbuf.req_addr !== 8'h05) begin
      n_fail++;
      $display("FAIL single_issue: got rdy0=%b rdy1=%b addr=%0h expected 1 0 5",
               rq0.req_rdy, rq1.req_rdy, tbuf.req_addr);
    end
    commit();
    rq0.req_val = 1'b0;
    settle();
    n_cmp++;
    if (rq0.resp_val !== 1'b1 || rq1.resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp: got rv0=%b rv1=%b expected 1 0", rq0.resp_val, rq1.resp_val);
    end
    commit();
    drain();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rq0.req_val = 1'b1; rq1.req_val = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rq0.req_addr = 8'(8'h10 + i); rq1.req_addr = 8'(8'h20 + i);
      settle();
      n_cmp++;
      if (rq0.req_rdy !== (i % 2 == 0) || rq1.req_rdy !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL alternate[%0d]: got rdy0=%b rdy1=%b expected %b %b", i,
                 rq0.req_rdy, rq1.req_rdy, (i % 2 == 0), (i % 2 == 1));
      end
      commit();
    end
    drain();
  endtask

  task automatic test_full_backpressure();
    bit reached;
    apply_reset();
    rq1.resp_rdy = 1'b0;
    rq0.req_val = 1'b1; rq1.req_val = 1'b1;
    rq0.req_addr = 8'h31; rq1.req_addr = 8'h41;
    reached = 1'b0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (tbuf.req_val === 1'b0) begin
        reached = 1'b1;
        break;
      end
      commit();
    end
    n_cmp++;
    if (!reached || outst_cnt !== 3'd4) begin
      n_fail++;
      $display("FAIL full_stall: got reached=%b cnt=%0d expected 1 4", reached, outst_cnt);
    end
    commit();
    rq1.resp_rdy = 1'b1;
    settle();
    n_cmp++;
    if (tbuf.req_val !== 1'b0 || tbuf.resp_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL no_bypass: got req_val=%b resp_rdy=%b expected 0 1", tbuf.req_val, tbuf.resp_rdy);
    end
    commit();
    settle();
    n_cmp++;
    if (tbuf.req_val !== 1'b1) begin
      n_fail++;
      $display("FAIL resume: got req_val=%b expected 1", tbuf.req_val);
    end
    commit();
    drain();
  endtask

  task automatic test_grant_and_pop();
    apply_reset();
    resp_en = 1'b0;
    rq0.req_val = 1'b1; rq0.req_addr = 8'h55;
    settle(); commit();
    rq0.req_addr = 8'h56;
    settle(); commit();
    resp_en = 1'b1; rq0.req_addr = 8'h57;
    settle();
    n_cmp++;
    if (outst_cnt !== 3'd2 || tbuf.req_val !== 1'b1 || tbuf.resp_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL grant_pop_pre: got cnt=%0d req_val=%b resp_rdy=%b expected 2 1 1",
               outst_cnt, tbuf.req_val, tbuf.resp_rdy);
    end
    commit();
    rq0.req_val = 1'b0;
    settle();
    n_cmp++;
    if (outst_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL grant_pop_cnt: got %0d expected 2", outst_cnt);
    end
    commit();
    drain();
  endtask

  task automatic test_orphan();
    orphan = 1'b1;
    settle();
    n_cmp++;
    if (tbuf.resp_rdy !== 1'b1 || rq0.resp_val !== 1'b0 || rq1.resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL orphan_accept: got rdy=%b rv0=%b rv1=%b expected 1 0 0",
               tbuf.resp_rdy, rq0.resp_val, rq1.resp_val);
    end
    commit();
    orphan = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_cmp++;
      if (err_orphan_resp !== 1'b1) begin
        n_fail++;
        $display("FAIL orphan_sticky[%0d]: got %b expected 1", k, err_orphan_resp);
      end
      commit();
    end
  endtask

  task automatic test_reset_mid_op();
    resp_en = 1'b0;
    rq0.req_val = 1'b1; rq0.req_addr = 8'h66;
    for (int k = 0; k < 3; k++) begin
      settle(); commit();
    end
    settle();
    n_cmp++;
    if (outst_cnt !== 3'd3) begin
      n_fail++;
      $display("FAIL midop_inflight: got %0d expected 3", outst_cnt);
    end
    rst = 1'b1;
    rq1.req_val = 1'b1; tbuf.resp_val = 1'b1;
    #1;
    n_cmp++;
    if ({rq0.req_rdy, rq1.req_rdy, tbuf.req_val, rq0.resp_val, rq1.resp_val,
         tbuf.resp_rdy, err_orphan_resp} !== 7'b0 || outst_cnt !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: got rdy0/rdy1/val/rv0/rv1/rrdy/err=%b%b%b%b%b%b%b cnt=%0d expected all 0",
               rq0.req_rdy, rq1.req_rdy, tbuf.req_val, rq0.resp_val, rq1.resp_val,
               tbuf.resp_rdy, err_orphan_resp, outst_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    resp_en = 1'b1;
    rq0.req_val = 1'b1; rq1.req_val = 1'b1;
    settle();
    n_cmp++;
    if (rq0.req_rdy !== 1'b1 || rq1.req_rdy !== 1'b0 || outst_cnt !== '0) begin
      n_fail++;
      $display("FAIL midop_tie: got rdy0=%b rdy1=%b cnt=%0d expected 1 0 0",
               rq0.req_rdy, rq1.req_rdy, outst_cnt);
    end
    commit();
    settle();
    n_cmp++;
    if (rq1.req_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_next: got rdy1=%b expected 1", rq1.req_rdy);
    end
    commit();
    drain();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; seq = 0;
    clear_model();
    apply_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_full_backpressure();
    test_grant_and_pop();
    test_orphan();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
